ysyx_24110006_hazard_ctrl: RTL and testbench
============================================

Name: ysyx_24110006_hazard_ctrl

Overview:
- Issue scheduler for the decode stage.
- Keeps a per-register pending-write scoreboard fed by IDU issue and WBU writeback.
- Produces the decode stall (drives IDU i_stall) and the pipeline flush (drives i_flush of IDU and later stages).
- Serialises CSR/FENCE/MRET: issue only into an empty pipeline, then block younger issue until that instruction writes back.

Parameters:
NUM_REGS, 16, architectural register count (RV32E); index 0 is hard-zero
REG_AW, 5, register index width
CNT_W, 2, pending counter width per register; max pending = 2^CNT_W-1

Ports:
i_clock  in  1  clock, all state on rising edge
i_reset  in  1  asynchronous, active-low reset
i_id_valid  in  1  IDU holds a decoded instruction (IDU o_vr.valid)
i_id_fire  in  1  instruction leaves IDU this cycle (o_vr.valid & o_vr.ready & ~o_stall)
i_id_rs1  in  REG_AW  source 1 index
i_id_rs2  in  REG_AW  source 2 index
i_id_rs1_used  in  1  rs1 is read
i_id_rs2_used  in  1  rs2 is read
i_id_rd  in  REG_AW  destination index
i_id_wen  in  1  instruction writes rd
i_id_serial  in  1  CSR, FENCE, MRET, ECALL/EBREAK or exception-tagged
i_wb_valid  in  1  WBU retires an instruction
i_wb_rd  in  REG_AW  retired destination
i_wb_wen  in  1  retired instruction wrote rd
i_redirect  in  1  EXU branch/jump redirect
i_trap  in  1  WBU trap/mret redirect; squashes everything in flight
o_stall  out  1  hold IDU
o_flush  out  1  flush younger stages
o_pipe_empty  out  1  all pending counters zero and state RUN
o_underflow  out  1  sticky: writeback to a register with zero pending

Behaviour:
- Reset (i_reset=0, asynchronous):
  - all counters 0; state RUN.
  - o_underflow=0; o_stall=0; o_flush=0; o_pipe_empty=1.
- Scoreboard: cnt[r] per r=1..NUM_REGS-1; r=0 never counted or checked.
  - inc = i_id_fire & i_id_wen & rd!=0.
  - dec = i_wb_valid & i_wb_wen & wb_rd!=0.
  - Same register inc and dec in one cycle: net unchanged.
  - dec on cnt 0: counter stays 0, o_underflow set until reset.
- raw = (rs1_used & rs1!=0 & cnt[rs1]!=0) | (rs2_used & rs2!=0 & cnt[rs2]!=0).
- sat = i_id_wen & rd!=0 & cnt[rd]==max.
- o_stall (combinational from registered state and i_id_*, zero latency; valid only when i_id_valid, else 0):
  - RUN: raw | sat | (i_id_serial & ~all_zero).
  - DRAIN: 1.
  - SERIAL: 1.
- Same-cycle writeback does NOT bypass the stall; the release comes one cycle later.
- FSM:
  - RUN -> SERIAL: i_id_fire & i_id_serial (pipeline already empty).
  - RUN -> DRAIN: i_id_valid & i_id_serial & ~all_zero; stall until empty.
  - DRAIN -> RUN: all_zero after the edge; the serial instruction then issues from RUN.
  - SERIAL -> RUN: on i_wb_valid (retirement of the serial instruction; it is the only one in flight).
- o_flush = i_redirect | i_trap (combinational).
- i_trap:
  - all counters cleared next edge; state -> RUN.
  - Overrides inc/dec in that cycle; the trapping instruction does not write back.
- i_redirect:
  - counters updated normally; state unchanged, except DRAIN -> RUN.
  - i_id_fire in the same cycle is ignored (IDU is being flushed).
- i_trap and i_redirect together: trap handling wins.
- o_pipe_empty = all_zero & state==RUN (registered-state derived).
- Reset mid-operation: state discarded immediately, no pulse on o_flush.

Decomposition:
- Shared package: FSM state enum (RUN, DRAIN, SERIAL), CNT_W/NUM_REGS defaults, register-index zero constant.
- One sub-module, ysyx_24110006_sb_cnt: single up/down saturating counter with clear, instantiated NUM_REGS-1 times.

Test Plan:
- RAW: issue wen rd=5, next cycle rs1=5 used -> o_stall=1 until the cycle after wb rd=5, then 0; rs1=0 with cnt irrelevant -> never stalls.
- Saturation: three issues to rd=3 without wb -> cnt[3]=3; fourth wen rd=3 -> o_stall=1; one wb rd=3 -> stall drops the next cycle.
- Serial drain: cnt[7]=1, i_id_serial -> state DRAIN, o_stall=1; wb rd=7 -> RUN, serial fires -> SERIAL; younger instruction stalled until i_wb_valid.
- Simultaneous: same cycle issue rd=4 and wb rd=4 with cnt[4]=1 -> cnt[4]=1; wb rd=9 with cnt 0 -> o_underflow=1 and sticky.
- Trap: cnt[1]=2, cnt[2]=1, state SERIAL, i_trap=1 with i_id_fire -> o_flush=1 that cycle; next cycle all counters 0, RUN, o_pipe_empty=1.
- Async reset asserted mid-DRAIN, between edges -> outputs reset values immediately, o_stall=0.

Source files
------------

// File: rtl/ysyx_24110006_hazard_ctrl_pkg.sv
// Shared types and defaults for the decode-stage issue scheduler.
package ysyx_24110006_hazard_ctrl_pkg;
  localparam int NUM_REGS_DEF = 16;
  localparam int REG_AW_DEF   = 5;
  localparam int CNT_W_DEF    = 2;
  localparam logic [REG_AW_DEF-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SERIAL = 2'd2
  } state_e;
endpackage

// File: rtl/ysyx_24110006_hazard_ctrl_if.sv
// IDU/WBU/redirect bundle seen by the hazard controller.
interface ysyx_24110006_hazard_ctrl_if
  import ysyx_24110006_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
);
  logic              i_id_valid;
  logic              i_id_fire;
  logic [REG_AW-1:0] i_id_rs1;
  logic [REG_AW-1:0] i_id_rs2;
  logic              i_id_rs1_used;
  logic              i_id_rs2_used;
  logic [REG_AW-1:0] i_id_rd;
  logic              i_id_wen;
  logic              i_id_serial;
  logic              i_wb_valid;
  logic [REG_AW-1:0] i_wb_rd;
  logic              i_wb_wen;
  logic              i_redirect;
  logic              i_trap;
  logic              o_stall;
  logic              o_flush;
  logic              o_pipe_empty;
  logic              o_underflow;

  modport master (
    output i_id_valid, i_id_fire, i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
           i_id_rd, i_id_wen, i_id_serial, i_wb_valid, i_wb_rd, i_wb_wen,
           i_redirect, i_trap,
    input  o_stall, o_flush, o_pipe_empty, o_underflow
  );

  modport slave (
    input  i_id_valid, i_id_fire, i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
           i_id_rd, i_id_wen, i_id_serial, i_wb_valid, i_wb_rd, i_wb_wen,
           i_redirect, i_trap,
    output o_stall, o_flush, o_pipe_empty, o_underflow
  );
endinterface

// File: rtl/ysyx_24110006_sb_cnt.sv
// One pending-write counter: saturating up/down with synchronous clear.
module ysyx_24110006_sb_cnt #(
  parameter int CNT_W = 2
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_zero,
  output logic o_max,
  output logic o_zero_d,
  output logic o_udf
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign o_zero = (cnt_q == '0);
  assign o_max  = &cnt_q;

  // inc and dec together cancel; clear beats both
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)                          cnt_d = '0;
    else if (i_inc & ~i_dec & ~o_max)   cnt_d = cnt_q + 1'b1;
    else if (i_dec & ~i_inc & ~o_zero)  cnt_d = cnt_q - 1'b1;
  end

  assign o_zero_d = (cnt_d == '0);
  assign o_udf    = i_dec & o_zero & ~i_clr;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
endmodule

// File: rtl/ysyx_24110006_hazard_ctrl.sv
// Decode issue scheduler: RAW/saturation scoreboard, serial-instruction
// drain/hold FSM, and pipeline flush.
module ysyx_24110006_hazard_ctrl
  import ysyx_24110006_hazard_ctrl_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input logic                         i_clock,
  input logic                         i_reset,
  ysyx_24110006_hazard_ctrl_if.slave  bus
);
  state_e state_q;
  logic   udf_q;

  logic [NUM_REGS-1:1] inc, dec, zero, zero_d, max, udf, hit1, hit2, sat_hit;
  logic fire_eff, wb_dec, all_zero, all_zero_d, raw, sat, stall;

  // a redirect flushes IDU, so its fire that cycle never reaches EXU
  assign fire_eff = bus.i_id_fire & ~bus.i_redirect & ~bus.i_trap;
  assign wb_dec   = bus.i_wb_valid & bus.i_wb_wen;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    localparam logic [REG_AW-1:0] IDX = REG_AW'(r);
    assign inc[r]     = fire_eff & bus.i_id_wen & (bus.i_id_rd == IDX);
    assign dec[r]     = wb_dec & (bus.i_wb_rd == IDX);
    assign hit1[r]    = bus.i_id_rs1_used & (bus.i_id_rs1 == IDX) & ~zero[r];
    assign hit2[r]    = bus.i_id_rs2_used & (bus.i_id_rs2 == IDX) & ~zero[r];
    assign sat_hit[r] = bus.i_id_wen & (bus.i_id_rd == IDX) & max[r];

    ysyx_24110006_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_clr    (bus.i_trap),
      .i_inc    (inc[r]),
      .i_dec    (dec[r]),
      .o_zero   (zero[r]),
      .o_max    (max[r]),
      .o_zero_d (zero_d[r]),
      .o_udf    (udf[r])
    );
  end

  assign all_zero   = &zero;
  assign all_zero_d = &zero_d;
  assign raw        = |{hit1, hit2};
  assign sat        = |sat_hit;

  // writeback in the same cycle does not release the stall
  always_comb begin
    stall = 1'b1;
    if (state_q == ST_RUN) stall = raw | sat | (bus.i_id_serial & ~all_zero);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_RUN;
      udf_q   <= 1'b0;
    end else begin
      udf_q <= udf_q | (|udf);
      if (bus.i_trap) state_q <= ST_RUN;
      else begin
        case (state_q)
          ST_RUN: begin
            if (fire_eff & bus.i_id_serial) state_q <= ST_SERIAL;
            else if (bus.i_id_valid & bus.i_id_serial & ~all_zero & ~bus.i_redirect)
              state_q <= ST_DRAIN;
          end
          ST_DRAIN:  if (bus.i_redirect | all_zero_d) state_q <= ST_RUN;
          // the serial instruction is alone in flight, so any retirement is it
          ST_SERIAL: if (bus.i_wb_valid) state_q <= ST_RUN;
          default:   state_q <= ST_RUN;
        endcase
      end
    end
  end

  assign bus.o_stall      = bus.i_id_valid & stall;
  assign bus.o_flush      = bus.i_redirect | bus.i_trap;
  assign bus.o_pipe_empty = all_zero & (state_q == ST_RUN);
  assign bus.o_underflow  = udf_q;
endmodule

// File: tb/tb_ysyx_24110006_hazard_ctrl.sv
// Cycle-vector bench for the hazard controller with an expected-output queue.
module tb_ysyx_24110006_hazard_ctrl;
  import ysyx_24110006_hazard_ctrl_pkg::*;

  typedef struct {
    logic v, f; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
    logic [4:0] rd; logic wen, ser, wbv; logic [4:0] wbrd; logic wbw, rdr, trp;
    logic es, ef, ee, eu;
  } vec_t;

  localparam int NV = 49;

  logic clk, rst_n;
  int   n_tests, n_fail;
  vec_t tbl [NV];
  vec_t sbq [$];

  ysyx_24110006_hazard_ctrl_if #(.REG_AW(5)) bus ();

  ysyx_24110006_hazard_ctrl #(.NUM_REGS(16), .REG_AW(5), .CNT_W(2)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(
    input logic v, f, input logic [4:0] rs1, input logic u1,
    input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
    input logic wen, ser, wbv, input logic [4:0] wbrd, input logic wbw, rdr, trp,
    input logic es, ef, ee, eu);
    vec_t t;
    t.v = v; t.f = f; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
    t.rd = rd; t.wen = wen; t.ser = ser; t.wbv = wbv; t.wbrd = wbrd;
    t.wbw = wbw; t.rdr = rdr; t.trp = trp;
    t.es = es; t.ef = ef; t.ee = ee; t.eu = eu;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    bus.i_id_valid = t.v;    bus.i_id_fire = t.f;
    bus.i_id_rs1 = t.rs1;    bus.i_id_rs1_used = t.u1;
    bus.i_id_rs2 = t.rs2;    bus.i_id_rs2_used = t.u2;
    bus.i_id_rd = t.rd;      bus.i_id_wen = t.wen;   bus.i_id_serial = t.ser;
    bus.i_wb_valid = t.wbv;  bus.i_wb_rd = t.wbrd;   bus.i_wb_wen = t.wbw;
    bus.i_redirect = t.rdr;  bus.i_trap = t.trp;
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    vec_t idle;
    n_tests = 0; n_fail = 0;
    idle = mk(0,0,REG_ZERO,0,REG_ZERO,0,REG_ZERO,0,0, 0,REG_ZERO,0,0,0, 0,0,1,0);

    //        v f rs1 u1 rs2 u2 rd wen ser wbv wbrd wbw rdr trp  stall flush empty udf
    tbl[0]  = mk(0,0, 0,0, 0,0,  0,0,0, 0, 0,0, 0,0, 0,0,1,0);
    tbl[1]  = mk(1,1, 0,0, 0,0,  5,1,0, 0, 0,0, 0,0, 0,0,1,0);
    tbl[2]  = mk(1,0, 5,1, 0,0,  0,0,0, 0, 0,0, 0,0, 1,0,0,0);
    tbl[3]  = mk(1,0, 5,1, 0,0,  0,0,0, 1, 5,1, 0,0, 1,0,0,0);
    tbl[4]  = mk(1,1, 5,1, 0,0,  0,0,0, 0, 0,0, 0,0, 0,0,1,0);
    tbl[5]  = mk(1,1, 0,1, 0,0,  6,1,0, 0, 0,0, 0,0, 0,0,1,0);
    tbl[6]  = mk(1,1, 0,1, 0,1,  0,0,0, 0, 0,0, 0,0, 0,0,0,0);
    tbl[7]  = mk(0,0, 0,0, 0,0,  0,0,0, 1, 6,1, 0,0, 0,0,0,0);
    tbl[8]  = mk(1,1, 0,0, 0,0,  2,1,0, 0, 0,0, 0,0, 0,0,1,0);
    tbl[9]  = mk(1,0, 0,0, 2,1,  0,0,0, 0, 0,0, 0,0, 1,0,0,0);
    tbl[10] = mk(1,1, 8,1, 2,0,  0,0,0, 0, 0,0, 0,0, 0,0,0,0);
    tbl[11] = mk(0,0, 0,0, 0,0,  0,0,0, 1, 2,1, 0,0, 0,0,0,0);
    tbl[12] = mk(1,1, 0,0, 0,0,  3,1,0, 0, 0,0, 0,0, 0,0,1,0);
    tbl[13] = mk(1,1, 0,0, 0,0,  3,1,0, 0, 0,0, 0,0, 0,0,0,0);
    tbl[14] = mk(1,1, 0,0, 0,0,  3,1,0, 0, 0,0, 0,0, 0,0,0,0);
    tbl[15] = mk(1,0, 0,0, 0,0,  3,1,0, 0, 0,0, 0,0, 1,0,0,0);
    tbl[16] = mk(1,0, 0,0, 0,0,  3,1,0, 1, 3,1, 0,0, 1,0,0,0);
    tbl[17] = mk(1,1, 0,0, 0,0,  3,1,0, 0, 0,0, 0,0, 0,0,0,0);
    tbl[18] = mk(0,0, 0,0, 0,0,  0,0,0, 1, 3,1, 0,0, 0,0,0,0);
    tbl[19] = mk(0,0, 0,0, 0,0,  0,0,0, 1, 3,1, 0,0, 0,0,0,0);
    tbl[20] = mk(0,0, 0,0, 0,0,  0,0,0, 1, 3,1, 0,0, 0,0,0,0);
    tbl[21] = mk(1,1, 0,0, 0,0,  7,1,0, 0, 0,0, 0,0, 0,0,1,0);
    tbl[22] = mk(1,0, 0,0, 0,0,  0,0,1, 0, 0,0, 0,0, 1,0,0,0);
    tbl[23] = mk(1,0, 0,0, 0,0,  0,0,1, 1, 7,1, 0,0, 1,0,0,0);
    tbl[24] = mk(1,1, 0,0, 0,0,  0,0,1, 0, 0,0, 0,0, 0,0,1,0);
    tbl[25] = mk(1,0, 0,0, 0,0,  8,1,0, 0, 0,0, 0,0, 1,0,0,0);
    tbl[26] = mk(1,0, 0,0, 0,0,  8,1,0, 1, 0,0, 0,0, 1,0,0,0);
    tbl[27] = mk(1,1, 0,0, 0,0,  8,1,0, 0, 0,0, 0,0, 0,0,1,0);
    tbl[28] = mk(0,0, 0,0, 0,0,  0,0,0, 1, 8,1, 0,0, 0,0,0,0);
    tbl[29] = mk(1,1, 0,0, 0,0,  4,1,0, 0, 0,0, 0,0, 0,0,1,0);
    tbl[30] = mk(1,1, 0,0, 0,0,  4,1,0, 1, 4,1, 0,0, 0,0,0,0);
    tbl[31] = mk(0,0, 0,0, 0,0,  0,0,0, 1, 4,1, 0,0, 0,0,0,0);
    tbl[32] = mk(0,0, 0,0, 0,0,  0,0,0, 1, 9,1, 0,0, 0,0,1,0);
    tbl[33] = mk(0,0, 0,0, 0,0,  0,0,0, 0, 0,0, 0,0, 0,0,1,1);
    tbl[34] = mk(0,0, 0,0, 0,0,  0,0,0, 0, 0,0, 0,0, 0,0,1,1);
    tbl[35] = mk(1,1, 0,0, 0,0,  1,1,1, 0, 0,0, 0,0, 0,0,1,1);
    tbl[36] = mk(1,1, 0,0, 0,0,  1,1,0, 0, 0,0, 0,0, 1,0,0,1);
    tbl[37] = mk(1,1, 0,0, 0,0,  2,1,0, 0, 0,0, 0,0, 1,0,0,1);
    tbl[38] = mk(1,1, 0,0, 0,0,  5,1,0, 0, 0,0, 0,1, 1,1,0,1);
    tbl[39] = mk(1,0, 1,1, 2,1,  0,0,0, 0, 0,0, 0,0, 0,0,1,1);
    tbl[40] = mk(1,1, 0,0, 0,0, 10,1,0, 0, 0,0, 0,0, 0,0,1,1);
    tbl[41] = mk(1,0, 0,0, 0,0,  0,0,1, 0, 0,0, 0,0, 1,0,0,1);
    tbl[42] = mk(1,1, 0,0, 0,0, 11,1,1, 0, 0,0, 1,0, 1,1,0,1);
    tbl[43] = mk(1,0,11,1, 0,0,  0,0,0, 0, 0,0, 0,0, 0,0,0,1);
    tbl[44] = mk(0,0, 0,0, 0,0,  0,0,0, 1,10,1, 0,0, 0,0,0,1);
    tbl[45] = mk(0,0, 0,0, 0,0,  0,0,0, 0, 0,0, 0,0, 0,0,1,1);
    tbl[46] = mk(1,1, 0,0, 0,0, 12,1,0, 0, 0,0, 0,0, 0,0,1,1);
    tbl[47] = mk(0,0, 0,0, 0,0,  0,0,0, 1,12,1, 1,1, 0,1,0,1);
    tbl[48] = mk(0,0, 0,0, 0,0,  0,0,0, 0, 0,0, 0,0, 0,0,1,1);

    rst_n = 1'b0;
    drive(idle);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.stall", bus.o_stall, 1'b0);
    chk("rst.flush", bus.o_flush, 1'b0);
    chk("rst.empty", bus.o_pipe_empty, 1'b1);
    chk("rst.udf",   bus.o_underflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      drive(tbl[i]);
      sbq.push_back(tbl[i]);
      @(negedge clk);
      e = sbq.pop_front();
      chk($sformatf("v%0d.stall", i), bus.o_stall,      e.es);
      chk($sformatf("v%0d.flush", i), bus.o_flush,      e.ef);
      chk($sformatf("v%0d.empty", i), bus.o_pipe_empty, e.ee);
      chk($sformatf("v%0d.udf",   i), bus.o_underflow,  e.eu);
    end

    // async reset while draining toward a serial instruction
    @(posedge clk); #1;
    drive(mk(1,1, 0,0, 0,0, 13,1,0, 0, 0,0, 0,0, 0,0,0,0));
    @(posedge clk); #1;
    drive(mk(1,0, 0,0, 0,0,  0,0,1, 0, 0,0, 0,0, 0,0,0,0));
    @(negedge clk);
    chk("pre_drain.stall", bus.o_stall, 1'b1);
    @(posedge clk); #2;
    chk("drain.stall", bus.o_stall, 1'b1);
    chk("drain.empty", bus.o_pipe_empty, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst.stall", bus.o_stall, 1'b0);
    chk("mid_rst.flush", bus.o_flush, 1'b0);
    chk("mid_rst.empty", bus.o_pipe_empty, 1'b1);
    chk("mid_rst.udf",   bus.o_underflow, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst.stall", bus.o_stall, 1'b0);
    chk("post_rst.empty", bus.o_pipe_empty, 1'b1);
    @(posedge clk); #1;
    drive(idle);
    @(negedge clk);
    chk("post_rst.udf", bus.o_underflow, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
